// File: rtl/xor_gate_checker.sv
// Self-test sequencer for a 2-input XOR gate under test.
// Walks vectors 00,10,01,11, samples gut_out after a settle delay and logs mismatches.
module xor_gate_checker #(
  parameter int SETTLE_CYC = 2,
  parameter int ERR_W      = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             gut_a,
  output logic             gut_b,
  input  logic             gut_out,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_cnt,
  output logic             fail_valid,
  output logic [1:0]       fail_vec
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam int CW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam logic [CW-1:0] LAST = CW'(SETTLE_CYC - 1);
  localparam logic [ERR_W-1:0] ERR_MAX = '1;

  state_t           state;
  logic [1:0]       idx;
  logic [1:0]       idx_nxt;
  logic [CW-1:0]    cnt;
  logic             mismatch;
  logic [ERR_W-1:0] err_nxt;

  assign idx_nxt  = idx + 2'd1;
  assign mismatch = gut_out != (gut_a ^ gut_b);

  always_comb begin
    err_nxt = err_cnt;
    if (mismatch && err_cnt != ERR_MAX)
      err_nxt = err_cnt + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      idx        <= '0;
      cnt        <= '0;
      gut_a      <= 1'b0;
      gut_b      <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      err_cnt    <= '0;
      fail_valid <= 1'b0;
      fail_vec   <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            state      <= RUN;
            idx        <= '0;
            cnt        <= '0;
            gut_a      <= 1'b0;
            gut_b      <= 1'b0;
            busy       <= 1'b1;
            pass       <= 1'b0;
            err_cnt    <= '0;
            fail_valid <= 1'b0;
            fail_vec   <= '0;
          end
        end
        RUN: begin
          if (cnt != LAST) begin
            cnt <= cnt + 1'b1;
          end else begin
            cnt     <= '0;
            err_cnt <= err_nxt;
            if (mismatch && !fail_valid) begin
              fail_vec   <= {gut_a, gut_b};
              fail_valid <= 1'b1;
            end
            // Last vector: the sample edge also closes the run
            if (idx == 2'd3) begin
              state <= IDLE;
              busy  <= 1'b0;
              done  <= 1'b1;
              gut_a <= 1'b0;
              gut_b <= 1'b0;
              pass  <= (err_nxt == '0);
            end else begin
              idx   <= idx_nxt;
              gut_a <= idx_nxt[0];
              gut_b <= idx_nxt[1];
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
